// File: rtl/vga_pkg.sv
// Shared constants for the shot link controller: TX state codes, frame header
// defaults and the two-bit result encodings.
package vga_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_HDR = 3'd1;
  localparam logic [2:0] ST_WAIT_HDR = 3'd2;
  localparam logic [2:0] ST_SEND_PAY = 3'd3;
  localparam logic [2:0] ST_WAIT_PAY = 3'd4;
  localparam logic [2:0] ST_WAIT_RES = 3'd5;

  localparam logic [7:0] HDR_SHOT_DEF   = 8'hA5;
  localparam logic [7:0] HDR_RESULT_DEF = 8'hC3;

  localparam logic [1:0] MSG_NONE = 2'b00;
  localparam logic [1:0] MSG_MISS = 2'b01;
  localparam logic [1:0] MSG_HIT  = 2'b10;

  function automatic logic [1:0] msg_from_bit(input logic hit);
    return hit ? MSG_HIT : MSG_MISS;
  endfunction

endpackage

// File: rtl/shot_frame_rx.sv
// Two-byte frame parser: a SHOT or RESULT header arms it, the next byte is the
// payload. Strobes are combinational; the controller registers what it needs.
module shot_frame_rx
  import vga_pkg::*;
#(
  parameter logic [7:0] HDR_SHOT   = HDR_SHOT_DEF,
  parameter logic [7:0] HDR_RESULT = HDR_RESULT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       shot_valid,
  output logic       res_valid,
  output logic [7:0] payload
);

  logic armed_q, armed_d;
  logic is_shot_q, is_shot_d;

  always_comb begin
    armed_d   = armed_q;
    is_shot_d = is_shot_q;
    if (rx_valid) begin
      if (armed_q) begin
        armed_d = 1'b0;
      end else if (rx_data == HDR_SHOT) begin
        armed_d   = 1'b1;
        is_shot_d = 1'b1;
      end else if (rx_data == HDR_RESULT) begin
        armed_d   = 1'b1;
        is_shot_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      is_shot_q <= 1'b0;
    end else begin
      armed_q   <= armed_d;
      is_shot_q <= is_shot_d;
    end
  end

  assign shot_valid = rx_valid & armed_q & is_shot_q;
  assign res_valid  = rx_valid & armed_q & ~is_shot_q;
  assign payload    = rx_data;

endmodule

// File: rtl/shot_link_ctl.sv
// Shot exchange controller over a byte UART link. Define SHOT_LINK_TIMEOUT_EN to
// enable the RESULT timeout (sticky link_err, timed-out shot reported as a miss).
module shot_link_ctl
  import vga_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65_000_000,
  parameter logic [7:0]  HDR_SHOT       = HDR_SHOT_DEF,
  parameter logic [7:0]  HDR_RESULT     = HDR_RESULT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       addres_sent,
  input  logic [7:0] check_out,
  input  logic       own_hit,
  input  logic       own_hit_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_done,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [1:0] msg_in,
  output logic [1:0] msg_send,
  output logic [7:0] check_in,
  output logic       link_err
);

  logic [2:0] state_q, state_d;
  logic       as_q;
  logic       shot_pend_q, shot_pend_d;
  logic [7:0] shot_addr_q, shot_addr_d;
  logic       reply_pend_q, reply_pend_d;
  logic       reply_hit_q, reply_hit_d;
  logic       wait_own_q, wait_own_d;
  logic       cur_shot_q, cur_shot_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;
  logic [1:0] msg_in_q, msg_in_d;
  logic [1:0] msg_send_q, msg_send_d;
  logic [7:0] check_in_q, check_in_d;
  logic       shot_valid, res_valid;
  logic [7:0] payload;
  logic       shot_rise, shot_busy, timeout_hit;

  shot_frame_rx #(
    .HDR_SHOT   (HDR_SHOT),
    .HDR_RESULT (HDR_RESULT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .shot_valid (shot_valid),
    .res_valid  (res_valid),
    .payload    (payload)
  );

  assign shot_rise = addres_sent & ~as_q;
  // A shot is in flight from the moment it is latched until WAIT_RES resolves.
  assign shot_busy = shot_pend_q | (cur_shot_q & (state_q != ST_IDLE));

`ifdef SHOT_LINK_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic        link_err_q;

  assign timeout_hit = (state_q == ST_WAIT_RES) && (timer_q == TIMEOUT_CYCLES - 32'd1);
  assign timer_d     = (state_q == ST_WAIT_RES) ? timer_q + 32'd1 : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q    <= 32'd0;
      link_err_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      link_err_q <= link_err_q | timeout_hit;
    end
  end

  assign link_err = link_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign link_err       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    shot_pend_d  = shot_pend_q;
    shot_addr_d  = shot_addr_q;
    reply_pend_d = reply_pend_q;
    reply_hit_d  = reply_hit_q;
    wait_own_d   = wait_own_q;
    cur_shot_d   = cur_shot_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    msg_in_d     = msg_in_q;
    msg_send_d   = msg_send_q;
    check_in_d   = check_in_q;

    case (state_q)
      ST_IDLE: begin
        if (reply_pend_q) begin
          reply_pend_d = 1'b0;
          cur_shot_d   = 1'b0;
          state_d      = ST_SEND_HDR;
        end else if (shot_pend_q) begin
          shot_pend_d = 1'b0;
          cur_shot_d  = 1'b1;
          msg_in_d    = MSG_NONE;
          msg_send_d  = MSG_NONE;
          state_d     = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        tx_start_d = 1'b1;
        tx_data_d  = cur_shot_q ? HDR_SHOT : HDR_RESULT;
        state_d    = ST_WAIT_HDR;
      end
      ST_WAIT_HDR: if (tx_done) state_d = ST_SEND_PAY;
      ST_SEND_PAY: begin
        tx_start_d = 1'b1;
        tx_data_d  = cur_shot_q ? shot_addr_q : {7'd0, reply_hit_q};
        state_d    = ST_WAIT_PAY;
      end
      ST_WAIT_PAY: if (tx_done) state_d = cur_shot_q ? ST_WAIT_RES : ST_IDLE;
      ST_WAIT_RES: begin
        if (res_valid) begin
          msg_in_d = msg_from_bit(payload[0]);
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          msg_in_d = MSG_MISS;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Events are applied after the FSM so a same-cycle new request is not lost.
    if (shot_rise && !shot_busy) begin
      shot_pend_d = 1'b1;
      shot_addr_d = check_out;
    end
    if (shot_valid) begin
      check_in_d = payload;
      wait_own_d = 1'b1;
    end
    if (own_hit_valid && wait_own_q) begin
      wait_own_d   = 1'b0;
      msg_send_d   = msg_from_bit(own_hit);
      reply_pend_d = 1'b1;
      reply_hit_d  = own_hit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      as_q         <= 1'b0;
      shot_pend_q  <= 1'b0;
      shot_addr_q  <= 8'd0;
      reply_pend_q <= 1'b0;
      reply_hit_q  <= 1'b0;
      wait_own_q   <= 1'b0;
      cur_shot_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      tx_start_q   <= 1'b0;
      msg_in_q     <= MSG_NONE;
      msg_send_q   <= MSG_NONE;
      check_in_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      as_q         <= addres_sent;
      shot_pend_q  <= shot_pend_d;
      shot_addr_q  <= shot_addr_d;
      reply_pend_q <= reply_pend_d;
      reply_hit_q  <= reply_hit_d;
      wait_own_q   <= wait_own_d;
      cur_shot_q   <= cur_shot_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      msg_in_q     <= msg_in_d;
      msg_send_q   <= msg_send_d;
      check_in_q   <= check_in_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign msg_in   = msg_in_q;
  assign msg_send = msg_send_q;
  assign check_in = check_in_q;

endmodule

// File: tb/tb_shot_link_ctl.sv
// Bench for shot_link_ctl: expected TX bytes are queued by the stimulus and
// checked by a separate monitor that also plays the UART transmitter.
module tb_shot_link_ctl;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       addres_sent = 1'b0;
  logic [7:0] check_out = 8'd0;
  logic       own_hit = 1'b0;
  logic       own_hit_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [1:0] msg_in;
  logic [1:0] msg_send;
  logic [7:0] check_in;
  logic       link_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit outstanding = 1'b0;
  bit last_start  = 1'b0;
  int pend_done   = 0;
  int starts_seen = 0;
  int block_idx   = -1;

  always #5 clk = ~clk;

  shot_link_ctl #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk           (clk),
    .rst           (rst),
    .addres_sent   (addres_sent),
    .check_out     (check_out),
    .own_hit       (own_hit),
    .own_hit_valid (own_hit_valid),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .tx_done       (tx_done),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .msg_in        (msg_in),
    .msg_send      (msg_send),
    .check_in      (check_in),
    .link_err      (link_err)
  );

  // Monitor / UART model: checks every tx_start against the queue and answers
  // with tx_done a few cycles later (withheld for start number block_idx).
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (rst) begin
      outstanding = 1'b0;
      pend_done   = 0;
      last_start  = 1'b0;
    end else begin
      if (tx_start) begin
        starts_seen++;
        n_checks++;
        if (last_start || outstanding) begin
          n_fail++;
          $display("FAIL tx_start_spacing got start #%0d while busy required idle link", starts_seen);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected got %02h required no transmission", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp) begin
            n_fail++;
            $display("FAIL tx_byte got %02h required %02h", tx_data, mon_exp);
          end else begin
            $display("tx byte %02h", tx_data);
          end
        end
        outstanding = 1'b1;
        if (starts_seen != block_idx) pend_done = 4;
      end
      if (pend_done > 0) begin
        pend_done--;
        if (pend_done == 0) begin
          tx_done     = 1'b1;
          outstanding = 1'b0;
        end
      end
      last_start = tx_start;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got %02h required %02h", name, act, req);
    end else begin
      $display("check %s = %02h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    cyc(2);
  endtask

  task automatic shoot(input logic [7:0] addr);
    @(negedge clk);
    check_out   = addr;
    addres_sent = 1'b1;
    cyc(2);
    addres_sent = 1'b0;
    cyc(1);
  endtask

  task automatic own_strobe(input logic hit);
    @(negedge clk);
    own_hit       = hit;
    own_hit_valid = 1'b1;
    @(negedge clk);
    own_hit_valid = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || outstanding) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL tx_drain got %0d bytes still queued required 0 within %0d cycles", exp_q.size(), budget);
    end
    cyc(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no end of test required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cyc(3);
    chk("rst_tx_start", {7'd0, tx_start}, 8'h00);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_msg_in", {6'd0, msg_in}, 8'h00);
    chk("rst_msg_send", {6'd0, msg_send}, 8'h00);
    chk("rst_check_in", check_in, 8'h00);
    chk("rst_link_err", {7'd0, link_err}, 8'h00);
    rst = 1'b0;
    cyc(2);

    // Local shot 34, second edge during WAIT_RES is dropped, RESULT hit
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h34);
    shoot(8'h34);
    drain(200);
    chk("shot_msg_in_pending", {6'd0, msg_in}, 8'h00);
    shoot(8'h99);
    cyc(3);
    rx_byte(8'hC3);
    rx_byte(8'h01);
    chk("result_hit_msg_in", {6'd0, msg_in}, {6'd0, MSG_HIT});
    cyc(20);
    chk("dropped_shot_queue", 8'(exp_q.size()), 8'h00);

    // Opponent shot 52, miss reply
    rx_byte(8'hA5);
    rx_byte(8'h52);
    chk("opp_check_in_52", check_in, 8'h52);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h00);
    own_strobe(1'b0);
    chk("opp_msg_send_miss", {6'd0, msg_send}, {6'd0, MSG_MISS});
    drain(200);

    // Opponent shot 17, hit reply
    rx_byte(8'hA5);
    rx_byte(8'h17);
    chk("opp_check_in_17", check_in, 8'h17);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01);
    own_strobe(1'b1);
    chk("opp_msg_send_hit", {6'd0, msg_send}, {6'd0, MSG_HIT});
    drain(200);

    // Garbage plus stray RESULT outside WAIT_RES changes nothing
    rx_byte(8'h7F);
    rx_byte(8'hC3);
    rx_byte(8'h01);
    cyc(3);
    chk("stray_msg_in", {6'd0, msg_in}, {6'd0, MSG_HIT});
    chk("stray_msg_send", {6'd0, msg_send}, {6'd0, MSG_HIT});
    chk("stray_check_in", check_in, 8'h17);
    rx_byte(8'hA5);
    rx_byte(8'h2B);
    chk("resync_check_in", check_in, 8'h2B);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h00);
    own_strobe(1'b0);
    drain(200);

    // Reply and shot pending in the same cycle: reply goes first
    rx_byte(8'hA5);
    rx_byte(8'h21);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h46);
    @(negedge clk);
    check_out     = 8'h46;
    addres_sent   = 1'b1;
    own_hit       = 1'b1;
    own_hit_valid = 1'b1;
    @(negedge clk);
    own_hit_valid = 1'b0;
    cyc(1);
    addres_sent = 1'b0;
    drain(300);
    chk("both_msg_send_cleared", {6'd0, msg_send}, 8'h00);
    chk("both_msg_in_cleared", {6'd0, msg_in}, 8'h00);
    rx_byte(8'hC3);
    rx_byte(8'h00);
    chk("result_miss_msg_in", {6'd0, msg_in}, {6'd0, MSG_MISS});

    // SHOT frame received during WAIT_RES, reply held until FSM is idle
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h63);
    shoot(8'h63);
    drain(200);
    rx_byte(8'hA5);
    rx_byte(8'h0A);
    chk("waitres_check_in", check_in, 8'h0A);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h01);
    own_strobe(1'b1);
    cyc(3);
    chk("waitres_msg_send", {6'd0, msg_send}, {6'd0, MSG_HIT});
    chk("waitres_reply_held", 8'(exp_q.size()), 8'h02);
    rx_byte(8'hC3);
    rx_byte(8'h01);
    drain(200);
    chk("waitres_msg_in", {6'd0, msg_in}, {6'd0, MSG_HIT});

    // No RESULT after a shot
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h11);
    shoot(8'h11);
    drain(200);
`ifdef SHOT_LINK_TIMEOUT_EN
    cyc(90);
    chk("timeout_not_yet", {7'd0, link_err}, 8'h00);
    cyc(20);
    chk("timeout_link_err", {7'd0, link_err}, 8'h01);
    chk("timeout_msg_in", {6'd0, msg_in}, {6'd0, MSG_MISS});
`else
    cyc(150);
    chk("no_timeout_link_err", {7'd0, link_err}, 8'h00);
    chk("no_timeout_msg_in", {6'd0, msg_in}, 8'h00);
    rx_byte(8'hC3);
    rx_byte(8'h01);
    chk("late_result_msg_in", {6'd0, msg_in}, {6'd0, MSG_HIT});
`endif

    // Reset while the payload byte is outstanding
    block_idx = starts_seen + 2;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h77);
    shoot(8'h77);
    begin
      int n = 0;
      while (starts_seen < block_idx && n < 200) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (starts_seen < block_idx) begin
        n_fail++;
        $display("FAIL wait_pay_reach got %0d starts required %0d", starts_seen, block_idx);
      end
    end
    cyc(3);
    rst = 1'b1;
    #1;
    chk("midrst_tx_start", {7'd0, tx_start}, 8'h00);
    chk("midrst_tx_data", tx_data, 8'h00);
    chk("midrst_msg_in", {6'd0, msg_in}, 8'h00);
    chk("midrst_msg_send", {6'd0, msg_send}, 8'h00);
    chk("midrst_check_in", check_in, 8'h00);
    chk("midrst_link_err", {7'd0, link_err}, 8'h00);
    cyc(2);
    rst = 1'b0;
    block_idx = -1;
    cyc(2);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    shoot(8'h3C);
    drain(200);
    rx_byte(8'hC3);
    rx_byte(8'h01);
    chk("post_rst_msg_in", {6'd0, msg_in}, {6'd0, MSG_HIT});
    cyc(10);
    chk("final_queue_empty", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
